// File: rtl/warmboot_pkg.sv
// Shared types and constants for the WARMBOOT sequencer.
// Bus map, unlock keys, FSM and boot-source encodings.
package warmboot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_WAIT
  } state_e;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_SW,
    SRC_PIN,
    SRC_WDT
  } src_e;

  localparam logic [1:0] ADR_CTRL     = 2'd0;
  localparam logic [1:0] ADR_STATUS   = 2'd1;
  localparam logic [1:0] ADR_WDT_LOAD = 2'd2;
  localparam logic [1:0] ADR_WDT_KICK = 2'd3;

  localparam logic [7:0] CTRL_KEY = 8'hA5;
  localparam logic [7:0] KICK_KEY = 8'h5A;

endpackage

// File: rtl/warmboot_debounce.sv
// Boot pin synchroniser and debouncer.
// Emits a single-cycle fire per press; re-arms once the pin is seen low.
module warmboot_debounce
  import warmboot_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic fire
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic s1, s2, armed;
  logic [CW-1:0] cnt;

  assign fire = s2 & armed & (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      armed <= 1'b1;
    end else begin
      s1 <= pin;
      s2 <= s1;
      if (!s2) begin
        cnt   <= '0;
        armed <= 1'b1;
      end else begin
        if (fire) armed <= 1'b0;
        if (cnt != LAST) cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/warmboot_ctrl.sv
// Wishbone WARMBOOT sequencer: arbitrates watchdog, pin and software
// boot requests and drives SLOT/BOOT with setup and pulse timing.
module warmboot_ctrl
  import warmboot_pkg::*;
#(
  parameter int         SETUP_CYCLES    = 4,
  parameter int         PULSE_CYCLES    = 8,
  parameter int         TIMEOUT_CYCLES  = 1024,
  parameter int         DEBOUNCE_CYCLES = 16,
  parameter int         WDT_W           = 24,
  parameter logic [3:0] PIN_SLOT        = 4'd1,
  parameter logic [3:0] FALLBACK_SLOT   = 4'd0
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic [1:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  input  logic        i_boot_pin,
  output logic [3:0]  o_slot,
  output logic        o_boot,
  output logic        o_user_rst,
  output logic        o_busy
);

  localparam logic [31:0] SL = 32'(SETUP_CYCLES - 1);
  localparam logic [31:0] PL = 32'(PULSE_CYCLES - 1);
  localparam logic [31:0] TL = 32'(TIMEOUT_CYCLES - 1);

  state_e state_q, state_n;
  src_e   src_q, src_n;
  logic [31:0] cnt_q, cnt_n;
  logic boot_q, boot_n;
  logic busy_q, busy_n;
  logic urst_q, urst_n;
  logic [3:0] slot_q, slot_n;

  logic ack_q;
  logic [31:0] rdt_q, rdata;
  logic [3:0] sw_slot;
  logic tmo_q, tmo_set;
  logic pend_sw, pend_pin, pend_wdt;
  logic g_sw, g_pin, g_wdt;
  logic [WDT_W-1:0] wdt_load, wdt_cnt;
  logic wdt_en, wdt_fire, pin_fire;
  logic acc, wr, sw_set, load_wr, kick_ok, idle;

  assign acc     = i_wb_cyc & ~ack_q;
  assign wr      = acc & i_wb_we;
  assign sw_set  = wr & (i_wb_adr == ADR_CTRL)
                 & (i_wb_dat[31:24] == CTRL_KEY) & i_wb_dat[8];
  assign load_wr = wr & (i_wb_adr == ADR_WDT_LOAD);
  assign kick_ok = wr & (i_wb_adr == ADR_WDT_KICK)
                 & (i_wb_dat[7:0] == KICK_KEY);
  assign idle    = (state_q == ST_IDLE);

  // Bus writes to the watchdog take precedence over expiry.
  assign wdt_fire = wdt_en & idle & ~load_wr & ~kick_ok
                  & (wdt_cnt <= WDT_W'(1));

  assign o_wb_ack   = ack_q;
  assign o_wb_rdt   = rdt_q;
  assign o_slot     = slot_q;
  assign o_boot     = boot_q;
  assign o_user_rst = urst_q;
  assign o_busy     = busy_q;

  warmboot_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk  (wb_clk),
    .rst  (wb_rst),
    .pin  (i_boot_pin),
    .fire (pin_fire)
  );

  always_comb begin
    rdata = '0;
    unique case (i_wb_adr)
      ADR_CTRL:     rdata = {28'd0, sw_slot};
      ADR_STATUS:   rdata = {20'd0, slot_q, 2'd0, src_q,
                             2'd0, tmo_q, busy_q};
      ADR_WDT_LOAD: rdata = 32'(wdt_load);
      ADR_WDT_KICK: rdata = '0;
      default:      rdata = '0;
    endcase
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q + 32'd1;
    boot_n  = boot_q;
    busy_n  = busy_q;
    urst_n  = urst_q;
    slot_n  = slot_q;
    src_n   = src_q;
    g_sw    = 1'b0;
    g_pin   = 1'b0;
    g_wdt   = 1'b0;
    tmo_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_n  = '0;
        urst_n = 1'b0;
        if (pend_wdt | pend_pin | pend_sw) begin
          state_n = ST_SETUP;
          busy_n  = 1'b1;
          urst_n  = 1'b1;
          if (pend_wdt) begin
            g_wdt  = 1'b1;
            slot_n = FALLBACK_SLOT;
            src_n  = SRC_WDT;
          end else if (pend_pin) begin
            g_pin  = 1'b1;
            slot_n = PIN_SLOT;
            src_n  = SRC_PIN;
          end else begin
            g_sw   = 1'b1;
            slot_n = sw_slot;
            src_n  = SRC_SW;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == SL) begin
          state_n = ST_PULSE;
          cnt_n   = '0;
          boot_n  = 1'b1;
        end
      end
      ST_PULSE: begin
        if (cnt_q == PL) begin
          state_n = ST_WAIT;
          cnt_n   = '0;
          boot_n  = 1'b0;
        end
      end
      ST_WAIT: begin
        if (cnt_q == TL) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
          busy_n  = 1'b0;
          urst_n  = 1'b0;
          tmo_set = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      boot_q  <= 1'b0;
      busy_q  <= 1'b0;
      urst_q  <= 1'b1;
      slot_q  <= '0;
      src_q   <= SRC_NONE;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      boot_q  <= boot_n;
      busy_q  <= busy_n;
      urst_q  <= urst_n;
      slot_q  <= slot_n;
      src_q   <= src_n;
    end
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      ack_q    <= 1'b0;
      rdt_q    <= '0;
      sw_slot  <= '0;
      tmo_q    <= 1'b0;
      wdt_load <= '0;
      wdt_cnt  <= '0;
      wdt_en   <= 1'b0;
      pend_sw  <= 1'b0;
      pend_pin <= 1'b0;
      pend_wdt <= 1'b0;
    end else begin
      ack_q <= acc;
      rdt_q <= (acc & ~i_wb_we) ? rdata : '0;
      if (wr && i_wb_adr == ADR_CTRL) sw_slot <= i_wb_dat[3:0];
      if (tmo_set) tmo_q <= 1'b1;
      else if (wr && i_wb_adr == ADR_STATUS && i_wb_dat[1])
        tmo_q <= 1'b0;
      if (load_wr) begin
        wdt_load <= i_wb_dat[WDT_W-1:0];
        wdt_cnt  <= i_wb_dat[WDT_W-1:0];
        wdt_en   <= |i_wb_dat[WDT_W-1:0];
      end else if (kick_ok || wdt_fire) begin
        wdt_cnt <= wdt_load;
      end else if (wdt_en && idle) begin
        wdt_cnt <= wdt_cnt - 1'b1;
      end
      // New requests win over the grant clear of the same cycle.
      pend_sw  <= (pend_sw & ~g_sw) | sw_set;
      pend_pin <= (pend_pin & ~g_pin) | pin_fire;
      pend_wdt <= (pend_wdt & ~g_wdt) | wdt_fire;
    end
  end

endmodule

// File: tb/tb_warmboot_ctrl.sv
// Self-checking bench for warmboot_ctrl: timeline model of boot
// sequences plus directed scenarios with literal expectations.
module tb_warmboot_ctrl;

  localparam int S = 4;
  localparam int P = 8;
  localparam int T = 1024;
  localparam int D = 16;

  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b1;
  logic [1:0]  i_wb_adr = '0;
  logic [31:0] i_wb_dat = '0;
  logic        i_wb_we = 1'b0;
  logic        i_wb_cyc = 1'b0;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack;
  logic        i_boot_pin = 1'b0;
  logic [3:0]  o_slot;
  logic        o_boot, o_user_rst, o_busy;

  always #5 wb_clk = ~wb_clk;

  warmboot_ctrl #(
    .SETUP_CYCLES(S), .PULSE_CYCLES(P), .TIMEOUT_CYCLES(T),
    .DEBOUNCE_CYCLES(D), .WDT_W(24),
    .PIN_SLOT(4'd1), .FALLBACK_SLOT(4'd0)
  ) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat),
    .i_wb_we(i_wb_we), .i_wb_cyc(i_wb_cyc),
    .o_wb_rdt(o_wb_rdt), .o_wb_ack(o_wb_ack),
    .i_boot_pin(i_boot_pin), .o_slot(o_slot),
    .o_boot(o_boot), .o_user_rst(o_user_rst), .o_busy(o_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model state: a sequence is a timeline measured from its start edge.
  bit          m_valid = 0, m_rst = 1, m_ack = 0, m_rd = 0;
  bit          m_on = 0, m_tmo = 0;
  int          m_age = 0;
  logic [31:0] m_rdt = '0;
  logic [3:0]  m_slot = '0, m_sw = '0;
  logic [1:0]  m_src = '0;
  bit          p_sw = 0, p_pin = 0, p_wdt = 0;
  bit          pd1 = 0, pd2 = 0, armed = 1;
  int          run = 0;
  logic [23:0] w_load = '0, w_cnt = '0;
  bit          w_en = 0;

  function automatic logic [31:0] regval(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_sw};
      2'd1:    return {20'd0, m_slot, 2'd0, m_src, 2'd0,
                       1'(m_tmo), 1'(m_on)};
      2'd2:    return {8'd0, w_load};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge wb_clk) begin : model
    bit acc, wr, was_on, gw, gp, gs, tset, fire, wfire, swset, smp;
    m_valid = 1;
    if (wb_rst) begin
      m_rst = 1; m_ack = 0; m_rd = 0; m_on = 0; m_tmo = 0;
      m_age = 0; m_slot = 0; m_sw = 0; m_src = 0;
      p_sw = 0; p_pin = 0; p_wdt = 0;
      pd1 = 0; pd2 = 0; armed = 1; run = 0;
      w_load = 0; w_cnt = 0; w_en = 0;
    end else begin
      m_rst = 0;
      acc = i_wb_cyc && !m_ack;
      wr = acc && i_wb_we;
      m_rd = acc && !i_wb_we;
      if (m_rd) m_rdt = regval(i_wb_adr);
      m_ack = acc;
      was_on = m_on;
      gw = 0; gp = 0; gs = 0; tset = 0;
      if (was_on) begin
        m_age++;
        if (m_age == S + P + T) begin m_on = 0; tset = 1; end
      end else if (p_wdt || p_pin || p_sw) begin
        m_on = 1; m_age = 0;
        if (p_wdt)      begin gw = 1; m_slot = 4'd0; m_src = 2'd3; end
        else if (p_pin) begin gp = 1; m_slot = 4'd1; m_src = 2'd2; end
        else            begin gs = 1; m_slot = m_sw; m_src = 2'd1; end
      end
      smp = pd2; pd2 = pd1; pd1 = i_boot_pin;
      fire = 0;
      if (smp) begin
        if (run < D) run++;
        if (run == D && armed) begin fire = 1; armed = 0; end
      end else begin
        run = 0; armed = 1;
      end
      wfire = 0;
      if (wr && i_wb_adr == 2'd2) begin
        w_load = i_wb_dat[23:0]; w_cnt = w_load; w_en = (w_load != 0);
      end else if (wr && i_wb_adr == 2'd3 && i_wb_dat[7:0] == 8'h5A) begin
        w_cnt = w_load;
      end else if (w_en && !was_on) begin
        if (w_cnt <= 1) begin wfire = 1; w_cnt = w_load; end
        else w_cnt = w_cnt - 1;
      end
      swset = 0;
      if (wr && i_wb_adr == 2'd0) begin
        m_sw = i_wb_dat[3:0];
        swset = (i_wb_dat[31:24] == 8'hA5) && i_wb_dat[8];
      end
      if (wr && i_wb_adr == 2'd1 && i_wb_dat[1]) m_tmo = 0;
      if (tset) m_tmo = 1;
      p_wdt = (p_wdt && !gw) || wfire;
      p_pin = (p_pin && !gp) || fire;
      p_sw  = (p_sw && !gs) || swset;
    end
  end

  always @(negedge wb_clk) begin
    if (m_valid) begin
      chk("ack", o_wb_ack, m_ack);
      chk("busy", o_busy, m_on);
      chk("boot", o_boot, m_on && m_age >= S && m_age < S + P);
      chk("user_rst", o_user_rst, m_rst || m_on);
      chk("slot", o_slot, m_slot);
      if (m_ack && m_rd) chk("rdt", o_wb_rdt, m_rdt);
    end
  end

  logic [3:0] starts[$];
  logic prev_busy = 1'b0;
  always @(negedge wb_clk) begin
    if (!wb_rst && o_busy === 1'b1 && prev_busy !== 1'b1)
      starts.push_back(o_slot);
    prev_busy = o_busy;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge wb_clk);
  endtask

  task automatic bus(input logic [1:0] a, input logic [31:0] d,
                     input logic we, output logic [31:0] q);
    int k;
    i_wb_adr = a; i_wb_dat = d; i_wb_we = we; i_wb_cyc = 1'b1;
    k = 0;
    do begin @(negedge wb_clk); k++; end
    while (o_wb_ack !== 1'b1 && k < 8);
    chk("ack_latency", k, 1);
    q = o_wb_rdt;
    i_wb_cyc = 1'b0; i_wb_we = 1'b0;
    @(negedge wb_clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] q;
    bus(a, d, 1'b1, q);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp,
                    input string name);
    logic [31:0] q;
    bus(a, 32'd0, 1'b0, q);
    chk(name, q, exp);
  endtask

  task automatic wait_busy(input logic v, input int bound, output int k);
    k = 0;
    while (o_busy !== v && k < bound) begin @(negedge wb_clk); k++; end
    if (o_busy !== v) chk("wait_busy_timeout", o_busy, v);
  endtask

  task automatic wait_boot(input logic v, input int bound, output int k);
    k = 0;
    while (o_boot !== v && k < bound) begin @(negedge wb_clk); k++; end
    if (o_boot !== v) chk("wait_boot_timeout", o_boot, v);
  endtask

  initial begin
    int k;
    logic [3:0] exp_starts [6];
    exp_starts = '{4'd3, 4'd1, 4'd0, 4'd1, 4'd5, 4'd2};

    tick(3);
    chk("rst_user_rst", o_user_rst, 1);
    chk("rst_boot", o_boot, 0);
    chk("rst_busy", o_busy, 0);
    wb_rst = 1'b0;
    tick(1);
    chk("user_rst_release", o_user_rst, 0);

    // Software boot to slot 3
    wr(2'd0, 32'hA500_0103);
    wait_busy(1'b1, 10, k);
    chk("sw_slot", o_slot, 3);
    chk("sw_user_rst", o_user_rst, 1);
    wait_boot(1'b1, 20, k);
    chk("setup_len", k, S);
    wait_boot(1'b0, 20, k);
    chk("pulse_len", k, P);
    wait_busy(1'b0, T + 10, k);
    chk("timeout_len", k, T);
    rd(2'd1, 32'h0000_0312, "status_sw");
    wr(2'd1, 32'h0000_0002);
    rd(2'd1, 32'h0000_0310, "status_clr");

    // Writes without a valid trigger
    wr(2'd0, 32'h0000_0107);
    tick(20);
    chk("unkeyed_busy", o_busy, 0);
    rd(2'd0, 32'h0000_0007, "ctrl_slot7");
    wr(2'd0, 32'hA500_0004);
    tick(20);
    chk("nobit8_busy", o_busy, 0);
    rd(2'd0, 32'h0000_0004, "ctrl_slot4");

    // Pin: short glitch, then a long press
    i_boot_pin = 1'b1; tick(10); i_boot_pin = 1'b0;
    tick(30);
    chk("glitch_busy", o_busy, 0);
    i_boot_pin = 1'b1; tick(40); i_boot_pin = 1'b0;
    wait_busy(1'b1, 10, k);
    chk("pin_slot", o_slot, 1);
    wait_busy(1'b0, T + 40, k);
    tick(50);
    chk("pin_once", starts.size(), 2);
    rd(2'd1, 32'h0000_0122, "status_pin");

    // Watchdog kept alive, then left to expire
    wr(2'd2, 32'd100);
    rd(2'd2, 32'd100, "wdt_load_rb");
    repeat (6) begin
      tick(50);
      wr(2'd3, 32'h0000_005A);
    end
    chk("wdt_kicked", starts.size(), 2);
    wait_busy(1'b1, 200, k);
    chk("wdt_delay", (k >= 95 && k <= 105), 1);
    chk("wdt_slot", o_slot, 0);
    rd(2'd1, 32'h0000_0033, "status_wdt");

    // Pin and software both pending during the watchdog sequence
    wr(2'd2, 32'd0);
    i_boot_pin = 1'b1; tick(30); i_boot_pin = 1'b0;
    wr(2'd0, 32'hA500_0105);
    wait_busy(1'b0, T + 40, k);
    wait_busy(1'b1, 10, k);
    chk("prio_pin_first", o_slot, 1);
    wait_busy(1'b0, T + 40, k);
    wait_busy(1'b1, 10, k);
    chk("prio_sw_second", o_slot, 5);
    wait_busy(1'b0, T + 40, k);

    // Reset in the middle of the BOOT pulse
    wr(2'd0, 32'hA500_0102);
    wr(2'd0, 32'hA500_0106);
    chk("slot_held", o_slot, 2);
    wait_boot(1'b1, 20, k);
    tick(2);
    chk("in_pulse", o_boot, 1);
    wb_rst = 1'b1;
    tick(1);
    chk("rst_mid_boot", o_boot, 0);
    chk("rst_mid_urst", o_user_rst, 1);
    tick(1);
    wb_rst = 1'b0;
    tick(1);
    chk("post_rst_urst", o_user_rst, 0);
    tick(30);
    chk("post_rst_busy", o_busy, 0);

    chk("num_starts", starts.size(), 6);
    for (int i = 0; i < 6 && i < starts.size(); i++)
      chk("start_slot", starts[i], exp_starts[i]);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench did not finish");
  end

endmodule
